// File: rtl/seq_sub_pkg.sv
// Shared word width, controller state encoding and slice-width legality check
// for the sequential subtractor.
package seq_sub_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit slice_w_legal(input int w);
        case (w)
            1, 2, 4, 8, 16, 32: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit borrow-ripple subtractor: d = x - y - bi, bo = borrow out.
// Zero latency; no handshake, purely combinational.
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    logic br;

    always_comb begin
        d  = '0;
        br = bi;
        for (int k = 0; k < W; k++) begin
            d[k] = x[k] ^ y[k] ^ br;
            // Borrow propagates when the bits are equal, generates when x=0,y=1.
            br   = (~x[k] & y[k]) | (~(x[k] ^ y[k]) & br);
        end
        bo = br;
    end

endmodule

// File: rtl/seq_sub_32.sv
// Sequential 32-bit subtractor, SLICE_W bits per cycle; SEQ_SUB_OVF_EN enables the ovf flag.
// Latency 32/SLICE_W cycles start->done; no backpressure, start is ignored while busy.
module seq_sub_32
    import seq_sub_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] D,
    output logic              bout,
    output logic              ovf
);

    localparam int N     = WORD_W / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (!slice_w_legal(SLICE_W) || (WORD_W % SLICE_W) != 0) begin : g_bad_slice_w
            $error("seq_sub_32: SLICE_W=%0d must be one of 1,2,4,8,16,32", SLICE_W);
        end
    endgenerate

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   a_q, b_q;
    logic                borrow_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SLICE_W-1:0]  xs, ys, ds;
    logic                bo;
    logic                last;
    logic                accept;

    assign xs     = a_q[idx_q*SLICE_W +: SLICE_W];
    assign ys     = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last   = (idx_q == IDX_W'(N - 1));
    assign accept = (state_q == IDLE) && start;

    sub_slice #(.W(SLICE_W)) u_slice (
        .x  (xs),
        .y  (ys),
        .bi (borrow_q),
        .d  (ds),
        .bo (bo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            D        <= '0;
            bout     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= A;
                b_q      <= B;
                borrow_q <= bin;
                idx_q    <= '0;
            end else if (state_q == RUN) begin
                D[idx_q*SLICE_W +: SLICE_W] <= ds;
                borrow_q <= bo;
                idx_q    <= idx_q + 1'b1;
                if (last) bout <= bo;
            end
        end
    end

`ifdef SEQ_SUB_OVF_EN
    // Final D[31] is the MSB of the slice being written on the last RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state_q == RUN && last) begin
            ovf <= (a_q[WORD_W-1] ^ b_q[WORD_W-1]) & (ds[SLICE_W-1] ^ a_q[WORD_W-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_sub_32.sv
// Directed bench for seq_sub_32 with SLICE_W = 8, 1 and 32 instances sharing stimulus.
module tb_seq_sub_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic        bin;

    logic        busy8, done8, bout8, ovf8;
    logic        busy1, done1, bout1, ovf1;
    logic        busy32, done32, bout32, ovf32;
    logic [31:0] D8, D1, D32;

    int checks   = 0;
    int failures = 0;

    int          lat8, lat1, lat32;
    logic [31:0] r8d, r1d, r32d;
    logic        r8b, r1b, r32b, r8o, r1o, r32o;

`ifdef SEQ_SUB_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_sub_32 #(.SLICE_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bin(bin),
        .busy(busy8), .done(done8), .D(D8), .bout(bout8), .ovf(ovf8)
    );

    seq_sub_32 #(.SLICE_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bin(bin),
        .busy(busy1), .done(done1), .D(D1), .bout(bout1), .ovf(ovf1)
    );

    seq_sub_32 #(.SLICE_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bin(bin),
        .busy(busy32), .done(done32), .D(D32), .bout(bout32), .ovf(ovf32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Start one operation, scramble inputs afterwards, and capture each instance's result at its done pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
        lat8 = -1; lat1 = -1; lat32 = -1;
        @(negedge clk);
        A = a; B = b; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; bin = ~bi;
        check("busy_after_start", 32'(busy8), 32'd1);
        check("done_after_start", 32'(done8), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done8 && lat8 < 0) begin
                lat8 = c; r8d = D8; r8b = bout8; r8o = ovf8;
            end
            if (done1 && lat1 < 0) begin
                lat1 = c; r1d = D1; r1b = bout1; r1o = ovf1;
            end
            if (done32 && lat32 < 0) begin
                lat32 = c; r32d = D32; r32b = bout32; r32o = ovf32;
            end
            if (lat8 > 0 && c == lat8 + 1) begin
                check("busy_after_done", 32'(busy8), 32'd0);
                check("done_one_cycle", 32'(done8), 32'd0);
                check("d_held_after_done", D8, r8d);
            end
        end
    endtask

    int first_done, second_done;

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_d", D8, 32'h0);
        check("rst_bout", 32'(bout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        rst = 1'b0;

        run_op(32'h0000000A, 32'h00000003, 1'b0);
        check("sub10_3_d", r8d, 32'h00000007);
        check("sub10_3_bout", 32'(r8b), 32'd0);
        check("sub10_3_ovf", 32'(r8o), 32'd0);
        check("sub10_3_lat8", 32'(lat8), 32'd4);

        run_op(32'h00000000, 32'h00000001, 1'b0);
        check("sub0_1_d", r8d, 32'hFFFFFFFF);
        check("sub0_1_bout", 32'(r8b), 32'd1);
        check("sub0_1_ovf", 32'(r8o), 32'd0);

        run_op(32'h80000000, 32'h00000001, 1'b0);
        check("ovf_d8", r8d, 32'h7FFFFFFF);
        check("ovf_bout8", 32'(r8b), 32'd0);
        check("ovf_flag8", 32'(r8o), 32'(OVF_EN));
        check("ovf_flag1", 32'(r1o), 32'(OVF_EN));
        check("ovf_flag32", 32'(r32o), 32'(OVF_EN));

        run_op(32'h12345678, 32'h12345678, 1'b1);
        check("eq_bin_d8", r8d, 32'hFFFFFFFF);
        check("eq_bin_bout8", 32'(r8b), 32'd1);
        check("eq_bin_lat8", 32'(lat8), 32'd4);
        check("eq_bin_d1", r1d, 32'hFFFFFFFF);
        check("eq_bin_bout1", 32'(r1b), 32'd1);
        check("eq_bin_lat1", 32'(lat1), 32'd32);
        check("eq_bin_d32", r32d, 32'hFFFFFFFF);
        check("eq_bin_bout32", 32'(r32b), 32'd1);
        check("eq_bin_lat32", 32'(lat32), 32'd1);

        // start held high through RUN/DONE: second operation begins only from IDLE.
        first_done = -1; second_done = -1;
        @(negedge clk);
        A = 32'd5; B = 32'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 32'd9; B = 32'd9;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done8) begin
                if (first_done < 0) begin
                    first_done = c;
                    check("hold_first_d", D8, 32'd3);
                end else if (second_done < 0) begin
                    second_done = c;
                    check("hold_second_d", D8, 32'd0);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("hold_first_lat", 32'(first_done), 32'd4);
        check("hold_second_lat", 32'(second_done), 32'd10);
        repeat (40) @(negedge clk);

        // Abort two cycles into RUN; low two slices of 0xDEADBEEF-1-1 are already written.
        @(negedge clk);
        A = 32'hDEADBEEF; B = 32'h00000001; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_partial_d", D8, 32'h0000BEED);
        rst = 1'b1;
        #1;
        check("abort_rst_d", D8, 32'h0);
        check("abort_rst_bout", 32'(bout8), 32'd0);
        check("abort_rst_ovf", 32'(ovf8), 32'd0);
        check("abort_rst_busy", 32'(busy8), 32'd0);
        check("abort_rst_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd7, 32'd7, 1'b0);
        check("post_abort_d", r8d, 32'h0);
        check("post_abort_bout", 32'(r8b), 32'd0);
        check("post_abort_lat8", 32'(lat8), 32'd4);
        check("post_abort_d1", r1d, 32'h0);
        check("post_abort_d32", r32d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
